bank_op_sched: RTL and testbench

Sequences single-bank SRAM operations for the 8-bank array and drives the per-bank precharge, wordline and sense-amp strobes. Two requesters share the bank strobes through a 2-way round-robin arbiter:
- Port A: host MAC-mode read/write, differential.
- Port B: CAM search, single-ended read.
Each granted operation runs through multi-cycle phases: precharge, wordline, sense, recover. The phase lengths are parameterised.

---
 rtl/bank_sched_pkg.sv | 14 +
 rtl/bank_rr_arb.sv | 28 ++
 rtl/bank_op_sched.sv | 172 +++++++++++++++++
 tb/tb_bank_op_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bank_sched_pkg.sv
// Shared types and constants for the bank operation sequencer.
package bank_sched_pkg;

  typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, REC} state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Per-bit idle levels of the strobes; replicated to NBANK at the use site
  localparam logic PREB_IDLE    = 1'b0;
  localparam logic SAMPLEB_IDLE = 1'b1;
  localparam logic SA_EN_IDLE   = 1'b0;

endpackage

// File: rtl/bank_rr_arb.sv
// 2-way round-robin arbiter; priority bit 0 favours port A, 1 favours port B.
module bank_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic pri_q, pri_d;

  always_comb begin
    gnt   = 2'b00;
    pri_d = pri_q;
    if (en) begin
      if (req == 2'b11) gnt = pri_q ? 2'b10 : 2'b01;
      else              gnt = req;
      // Any grant hands priority to the other port
      if (|req) pri_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri_q <= 1'b0;
    else     pri_q <= pri_d;
  end

endmodule

// File: rtl/bank_op_sched.sv
// Bank operation sequencer: arbitrates host (A) and CAM (B) requests and drives
// per-bank precharge / wordline / sense strobes. Optional macro OPCNT_EN adds op_cnt.
module bank_op_sched
  import bank_sched_pkg::*;
#(
  parameter int NBANK   = 8,
  parameter int BW      = 3,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 2,
  parameter int SA_CYC  = 1,
  parameter int CNTW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_wr,
  input  logic [BW-1:0]    a_bank,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [BW-1:0]    b_bank,
  output logic [NBANK-1:0] preb,
  output logic [NBANK-1:0] sampleb,
  output logic [NBANK-1:0] sa_en,
  output logic             mac_en,
  output logic             busy,
  output logic             done,
  output logic             done_src
`ifdef OPCNT_EN
  ,
  output logic [15:0]      op_cnt
`endif
);

  localparam int CNT_MAX = (1 << CNTW) - 1;

  if (PRE_CYC < 1 || WL_CYC < 1 || SA_CYC < 1) begin : g_zero_len
    $fatal(1, "bank_op_sched: phase lengths must be >= 1");
  end
  if (PRE_CYC > CNT_MAX || WL_CYC > CNT_MAX || SA_CYC > CNT_MAX) begin : g_cnt_ovf
    $fatal(1, "bank_op_sched: phase length overflows CNTW");
  end

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic              wr_q, wr_d;
  logic              src_q, src_d;
  logic              mac_en_q, mac_en_d;
  logic [NBANK-1:0]  preb_q, preb_d;
  logic [NBANK-1:0]  sampleb_q, sampleb_d;
  logic [NBANK-1:0]  sa_en_q, sa_en_d;
  logic [1:0]        gnt;
  logic              hs;

  bank_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .en  (state_q == IDLE),
    .gnt (gnt)
  );

  assign hs = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = PRE;
        cnt_d   = CNTW'(PRE_CYC - 1);
      end
      PRE: if (cnt_q == '0) begin
        state_d = WL;
        cnt_d   = CNTW'(WL_CYC - 1);
      end else cnt_d = cnt_q - CNTW'(1);
      WL: if (cnt_q == '0) begin
        state_d = wr_q ? REC : SENSE;
        cnt_d   = CNTW'(SA_CYC - 1);
      end else cnt_d = cnt_q - CNTW'(1);
      SENSE: if (cnt_q == '0) state_d = REC;
             else             cnt_d   = cnt_q - CNTW'(1);
      REC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_ready  = gnt[0];
    b_ready  = gnt[1];
    busy     = (state_q != IDLE);
    done     = (state_q == REC);
    done_src = src_q;
  end

  // Op capture and registered strobes keyed off the next state, so they line up with state_q
  always_comb begin
    bank_d    = bank_q;
    wr_d      = wr_q;
    src_d     = src_q;
    mac_en_d  = mac_en_q;
    if (hs) begin
      bank_d   = gnt[1] ? b_bank : a_bank;
      wr_d     = gnt[1] ? 1'b0 : a_wr;
      src_d    = gnt[1] ? SRC_B : SRC_A;
      mac_en_d = gnt[0];
    end
    preb_d    = {NBANK{PREB_IDLE}};
    sampleb_d = {NBANK{SAMPLEB_IDLE}};
    sa_en_d   = {NBANK{SA_EN_IDLE}};
    for (int k = 0; k < NBANK; k++) begin
      if (bank_q == BW'(k) && (state_d == WL || state_d == SENSE)) begin
        preb_d[k]    = 1'b1;
        sampleb_d[k] = 1'b0;
        sa_en_d[k]   = (state_d == SENSE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q    <= '0;
      wr_q      <= 1'b0;
      src_q     <= SRC_A;
      mac_en_q  <= 1'b0;
      preb_q    <= {NBANK{PREB_IDLE}};
      sampleb_q <= {NBANK{SAMPLEB_IDLE}};
      sa_en_q   <= {NBANK{SA_EN_IDLE}};
    end else begin
      bank_q    <= bank_d;
      wr_q      <= wr_d;
      src_q     <= src_d;
      mac_en_q  <= mac_en_d;
      preb_q    <= preb_d;
      sampleb_q <= sampleb_d;
      sa_en_q   <= sa_en_d;
    end
  end

  assign preb    = preb_q;
  assign sampleb = sampleb_q;
  assign sa_en   = sa_en_q;
  assign mac_en  = mac_en_q;

`ifdef OPCNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (done && op_cnt_q != 16'hFFFF) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_cnt_q <= '0;
    else     op_cnt_q <= op_cnt_d;
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_bank_op_sched.sv
// Scoreboard bench for bank_op_sched: driver queues expected strobe snapshots and
// done events; a negedge monitor pops and compares them.
module tb_bank_op_sched;
  import bank_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, a_wr = 1'b0, b_valid = 1'b0;
  logic [2:0] a_bank = 3'd0, b_bank = 3'd0;
  logic       a_ready, b_ready, mac_en, busy, done, done_src;
  logic [7:0] preb, sampleb, sa_en;
`ifdef OPCNT_EN
  logic [15:0] op_cnt;
`endif

  bank_op_sched #(.NBANK(8), .BW(3), .PRE_CYC(2), .WL_CYC(2), .SA_CYC(1), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_bank(a_bank),
    .b_valid(b_valid), .b_ready(b_ready), .b_bank(b_bank),
    .preb(preb), .sampleb(sampleb), .sa_en(sa_en),
    .mac_en(mac_en), .busy(busy), .done(done), .done_src(done_src)
`ifdef OPCNT_EN
    , .op_cnt(op_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] preb, sampleb, sa_en;
    logic       busy, done, a_rdy, b_rdy, chk_m;
  } snap_t;
  typedef struct { int cyc; logic src; } dn_t;

  snap_t sq[$];
  dn_t   dq[$];
  int    checks = 0, errors = 0, tmo = 0;
  bit    drv_done = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_snap(int c, logic [7:0] pb, logic [7:0] sb, logic [7:0] se,
                           logic bz, logic dn, logic ar, logic br, logic cm);
    snap_t s;
    s.cyc = c; s.preb = pb; s.sampleb = sb; s.sa_en = se;
    s.busy = bz; s.done = dn; s.a_rdy = ar; s.b_rdy = br; s.chk_m = cm;
    sq.push_back(s);
  endtask

  task automatic push_idle(int c, logic ar, logic br, logic cm);
    push_snap(c, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, ar, br, cm);
  endtask

  // Cycle i after the accept cycle: PRE 1-2, WL 3-4, SENSE 5 (reads), REC last
  task automatic push_op(int acc, logic wr, logic [2:0] bank, logic src);
    logic [7:0] m;
    int len;
    logic wl, se;
    dn_t d;
    m   = 8'h01 << bank;
    len = wr ? 5 : 6;
    for (int i = 1; i <= len; i++) begin
      se = (i == 5) && !wr;
      wl = (i == 3) || (i == 4) || se;
      push_snap(acc + i, wl ? m : 8'h00, wl ? ~m : 8'hFF, se ? m : 8'h00,
                1'b1, (i == len), 1'b0, 1'b0, 1'b0);
    end
    d.cyc = acc + len; d.src = src;
    dq.push_back(d);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic op(logic src, logic wr, logic [2:0] bank, bit push, output int acc);
    int n;
    n = 0;
    if (src == SRC_A) begin a_wr = wr; a_bank = bank; a_valid = 1'b1; end
    else begin b_bank = bank; b_valid = 1'b1; end
    while (1) begin
      @(negedge clk);
      if ((src == SRC_A) ? a_ready : b_ready) break;
      n++;
      if (n > 40) begin tmo++; break; end
    end
    acc = cyc;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    if (push) push_op(acc, wr, bank, src);
  endtask

  initial begin
    int acc, g0;
    @(posedge clk); #1;
    push_snap(1, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 1);
    push_snap(2, 8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 1);
    wait_until(3);
    rst = 1'b0;
    for (int c = 3; c <= 7; c++) push_idle(c, 0, 0, 1);
    wait_until(8);

    // A read, bank 3
    op(SRC_A, 1'b0, 3'd3, 1'b1, acc);
    push_idle(acc + 7, 0, 0, 0);
    wait_until(acc + 8);

    // A write, bank 0, with a read already waiting: ready returns in cycle 6, not 5
    op(SRC_A, 1'b1, 3'd0, 1'b1, acc);
    a_wr = 1'b0; a_bank = 3'd3; a_valid = 1'b1;
    push_idle(acc + 6, 1, 0, 0);
    op(SRC_A, 1'b0, 3'd3, 1'b1, acc);
    push_idle(acc + 7, 0, 0, 0);
    wait_until(acc + 8);

    // Reset in the second WL cycle of a bank 5 read
    op(SRC_A, 1'b0, 3'd5, 1'b0, acc);
    push_snap(acc + 1, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 0);
    push_snap(acc + 2, 8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 0);
    push_snap(acc + 3, 8'h20, 8'hDF, 8'h00, 1, 0, 0, 0, 0);
    wait_until(acc + 4);
    #2 rst = 1'b1;
    push_idle(acc + 4, 0, 0, 1);
    push_idle(acc + 5, 0, 0, 1);
    wait_until(acc + 6);
    rst = 1'b0;

    // Both ports contending: A first after reset, then alternating every 7 cycles
    g0 = cyc;
    a_bank = 3'd1; b_bank = 3'd2; a_wr = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_idle(g0 + 7 * i, (i % 2) == 0, (i % 2) == 1, 0);
      push_op(g0 + 7 * i, 1'b0, ((i % 2) == 1) ? 3'd2 : 3'd1, ((i % 2) == 1) ? SRC_B : SRC_A);
    end
    push_idle(g0 + 28, 0, 0, 0);
    wait_until(g0 + 22);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_until(g0 + 31);
    drv_done = 1'b1;
  end

  initial begin
    snap_t s;
    dn_t   d;
    while (!drv_done) begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        chk("snap_cyc", cyc, s.cyc);
        chk("preb", preb, s.preb);
        chk("sampleb", sampleb, s.sampleb);
        chk("sa_en", sa_en, s.sa_en);
        chk("busy", busy, s.busy);
        chk("done", done, s.done);
        chk("a_ready", a_ready, s.a_rdy);
        chk("b_ready", b_ready, s.b_rdy);
        if (s.chk_m) begin
          chk("mac_en_rst", mac_en, 1'b0);
          chk("done_src_rst", done_src, 1'b0);
        end
      end
      if (done && !rst) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_cyc", cyc, d.cyc);
          chk("done_src", done_src, d.src);
          chk("mac_en", mac_en, d.src == SRC_A);
        end
      end
    end
    chk("done_pending", dq.size(), 0);
    chk("snap_pending", sq.size(), 0);
    chk("timeouts", tmo, 0);
`ifdef OPCNT_EN
    chk("op_cnt", op_cnt, 16'd7);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
